// File: rtl/a2d_arbiter.sv
// a2d_arbiter: shares one A2D converter between the motion IR sequencer (req0)
// and the battery/aux monitor (req1); one conversion in flight, round-robin grant.
module a2d_arbiter #(
  parameter int unsigned      CNT_W   = 12,
  parameter logic [CNT_W-1:0] TIMEOUT = 12'd2047
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_strt,
  input  logic [2:0]  req0_chnnl,
  input  logic        req1_strt,
  input  logic [2:0]  req1_chnnl,
  input  logic        a2d_cnv_cmplt,
  input  logic [11:0] a2d_res,
  output logic        a2d_strt_cnv,
  output logic [2:0]  a2d_chnnl,
  output logic [11:0] res,
  output logic        cmplt0,
  output logic        cmplt1,
  output logic        busy,
  output logic        err_timeout,
  output logic        ovr0,
  output logic        ovr1
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT - CNT_ONE;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       pend_q, pend_d;
  logic [2:0]       ch0_q, ch0_d, ch1_q, ch1_d;
  logic             cmplt_in_q;
  logic [11:0]      res_q, res_d;
  logic             cmplt0_q, cmplt0_d, cmplt1_q, cmplt1_d;
  logic             err_q, err_d;
  logic             ovr0_q, ovr0_d, ovr1_q, ovr1_d;
  logic             strt_q, strt_d;
  logic [2:0]       chnnl_q, chnnl_d;
  logic             busy_q, busy_d;

  logic             cmpl_ev_s;
  logic             done_s;
  logic             tmo_s;
  logic [1:0]       clr_s;
  logic [1:0]       keep_s;
  logic [1:0]       req_s;

  // A level already high on entry to WAIT was captured by cmplt_in_q, so it is no event.
  assign cmpl_ev_s = a2d_cnv_cmplt & ~cmplt_in_q;
  assign req_s     = {req1_strt, req0_strt};

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: grant selection, conversion supervision and timeout counting
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    done_s  = 1'b0;
    tmo_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_q[0] && pend_q[1]) begin
          gnt_d   = ~last_q;
          state_d = ST_LAUNCH;
        end else if (pend_q[0]) begin
          gnt_d   = 1'b0;
          state_d = ST_LAUNCH;
        end else if (pend_q[1]) begin
          gnt_d   = 1'b1;
          state_d = ST_LAUNCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cmpl_ev_s) begin
          done_s  = 1'b1;
          last_d  = gnt_q;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          tmo_s   = 1'b1;
          last_d  = gnt_q;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d   = cnt_q;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: request bookkeeping and next values of the registered outputs
  always_comb begin
    if (done_s || tmo_s) begin
      clr_s = gnt_q ? 2'b10 : 2'b01;
    end else begin
      clr_s = 2'b00;
    end
    // A strobe landing on the clearing cycle sees the slot as free, so it queues.
    keep_s   = pend_q & ~clr_s;
    pend_d   = keep_s | req_s;
    ovr0_d   = req_s[0] & keep_s[0];
    ovr1_d   = req_s[1] & keep_s[1];
    if (req_s[0] && !keep_s[0]) begin
      ch0_d = req0_chnnl;
    end else begin
      ch0_d = ch0_q;
    end
    if (req_s[1] && !keep_s[1]) begin
      ch1_d = req1_chnnl;
    end else begin
      ch1_d = ch1_q;
    end
    cmplt0_d = done_s & ~gnt_q;
    cmplt1_d = done_s & gnt_q;
    err_d    = tmo_s;
    if (done_s) begin
      res_d = a2d_res;
    end else begin
      res_d = res_q;
    end
    strt_d = (state_d == ST_LAUNCH);
    busy_d = (state_d == ST_LAUNCH) || (state_d == ST_WAIT);
    if (strt_d) begin
      chnnl_d = gnt_d ? ch1_q : ch0_q;
    end else begin
      chnnl_d = chnnl_q;
    end
  end

  // Datapath and registered output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= {CNT_W{1'b0}};
      pend_q     <= 2'b00;
      ch0_q      <= 3'd0;
      ch1_q      <= 3'd0;
      cmplt_in_q <= 1'b0;
      res_q      <= 12'd0;
      cmplt0_q   <= 1'b0;
      cmplt1_q   <= 1'b0;
      err_q      <= 1'b0;
      ovr0_q     <= 1'b0;
      ovr1_q     <= 1'b0;
      strt_q     <= 1'b0;
      chnnl_q    <= 3'd0;
      busy_q     <= 1'b0;
    end else begin
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      ch0_q      <= ch0_d;
      ch1_q      <= ch1_d;
      cmplt_in_q <= a2d_cnv_cmplt;
      res_q      <= res_d;
      cmplt0_q   <= cmplt0_d;
      cmplt1_q   <= cmplt1_d;
      err_q      <= err_d;
      ovr0_q     <= ovr0_d;
      ovr1_q     <= ovr1_d;
      strt_q     <= strt_d;
      chnnl_q    <= chnnl_d;
      busy_q     <= busy_d;
    end
  end

  assign a2d_strt_cnv = strt_q;
  assign a2d_chnnl    = chnnl_q;
  assign res          = res_q;
  assign cmplt0       = cmplt0_q;
  assign cmplt1       = cmplt1_q;
  assign busy         = busy_q;
  assign err_timeout  = err_q;
  assign ovr0         = ovr0_q;
  assign ovr1         = ovr1_q;

endmodule

// File: tb/tb_a2d_arbiter.sv
// tb_a2d_arbiter: directed scenarios plus randomized traffic, every cycle compared
// against a timestamp-based transaction model of the arbiter.
module tb_a2d_arbiter;

  localparam int TMO = 2047;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_strt, req1_strt;
  logic [2:0]  req0_chnnl, req1_chnnl;
  logic        a2d_cnv_cmplt;
  logic [11:0] a2d_res;
  logic        a2d_strt_cnv;
  logic [2:0]  a2d_chnnl;
  logic [11:0] res;
  logic        cmplt0, cmplt1, busy, err_timeout, ovr0, ovr1;

  always #5 clk = ~clk;

  a2d_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_strt(req0_strt), .req0_chnnl(req0_chnnl),
    .req1_strt(req1_strt), .req1_chnnl(req1_chnnl),
    .a2d_cnv_cmplt(a2d_cnv_cmplt), .a2d_res(a2d_res),
    .a2d_strt_cnv(a2d_strt_cnv), .a2d_chnnl(a2d_chnnl), .res(res),
    .cmplt0(cmplt0), .cmplt1(cmplt1), .busy(busy),
    .err_timeout(err_timeout), .ovr0(ovr0), .ovr1(ovr1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // transaction model: pending flags, owner and the cycle its conversion launched
  bit         m_pend [2];
  logic [2:0] m_ch   [2];
  int         m_owner, m_launch, m_last;
  bit         m_prev;
  logic        e_strt, e_busy, e_cmplt0, e_cmplt1, e_err, e_ovr0, e_ovr1;
  logic [2:0]  e_chnnl;
  logic [11:0] e_res;

  // A2D converter behaviour: 0 pulse, 1 sticky level, 2 silent
  int          a2d_mode, dly_lo, dly_hi, rise_at, fall_at;
  bit          fix_res;
  logic [11:0] res_val;

  task automatic chk(string tag, logic [11:0] obs, logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(string tag, int obs, int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend[0] = 0; m_pend[1] = 0; m_ch[0] = 3'd0; m_ch[1] = 3'd0;
    m_owner = -1; m_launch = 0; m_last = 1; m_prev = 0;
    e_strt = 0; e_busy = 0; e_cmplt0 = 0; e_cmplt1 = 0; e_err = 0;
    e_ovr0 = 0; e_ovr1 = 0; e_chnnl = 3'd0; e_res = 12'd0;
  endtask

  // expected outputs for cycle cyc+1 from the inputs of cycle cyc
  task automatic model_eval();
    bit ev;
    int fin, pick;
    ev = a2d_cnv_cmplt && !m_prev;
    fin = -1; pick = -1;
    e_strt = 0; e_busy = 0; e_cmplt0 = 0; e_cmplt1 = 0; e_err = 0; e_ovr0 = 0; e_ovr1 = 0;
    if (m_owner < 0) begin
      if (m_pend[0] && m_pend[1]) pick = (m_last == 0) ? 1 : 0;
      else if (m_pend[0]) pick = 0;
      else if (m_pend[1]) pick = 1;
      if (pick >= 0) begin
        m_owner = pick; m_launch = cyc + 1;
        e_strt = 1; e_busy = 1; e_chnnl = m_ch[pick];
      end
    end else if (cyc == m_launch) begin
      e_busy = 1;
    end else if (ev) begin
      e_res = a2d_res;
      if (m_owner == 0) e_cmplt0 = 1; else e_cmplt1 = 1;
      fin = m_owner;
    end else if (cyc - m_launch == TMO) begin
      e_err = 1;
      fin = m_owner;
    end else begin
      e_busy = 1;
    end
    if (fin >= 0) begin
      m_pend[fin] = 0; m_last = fin; m_owner = -1;
    end
    if (req0_strt) begin
      if (m_pend[0]) e_ovr0 = 1;
      else begin m_pend[0] = 1; m_ch[0] = req0_chnnl; end
    end
    if (req1_strt) begin
      if (m_pend[1]) e_ovr1 = 1;
      else begin m_pend[1] = 1; m_ch[1] = req1_chnnl; end
    end
    m_prev = a2d_cnv_cmplt;
  endtask

  task automatic a2d_update();
    if (e_strt) begin
      if (a2d_mode == 2) begin
        rise_at = -1;
        fall_at = a2d_cnv_cmplt ? cyc + 1 : -1;
      end else if (a2d_cnv_cmplt) begin
        fall_at = cyc + int'($urandom_range(1, 6));
        rise_at = fall_at + int'($urandom_range(1, 20));
      end else begin
        rise_at = cyc + int'($urandom_range(dly_lo, dly_hi));
        fall_at = -1;
      end
    end
    if (cyc == fall_at) begin a2d_cnv_cmplt = 1'b0; fall_at = -1; end
    if (cyc == rise_at) begin
      a2d_cnv_cmplt = 1'b1;
      a2d_res = fix_res ? res_val : 12'($urandom);
      rise_at = -1;
      fall_at = (a2d_mode == 0) ? cyc + 1 : -1;
    end
  endtask

  task automatic step();
    model_eval();
    @(posedge clk); #1;
    cyc++;
    chk("strt", {11'd0, a2d_strt_cnv}, {11'd0, e_strt});
    chk("chnnl", {9'd0, a2d_chnnl}, {9'd0, e_chnnl});
    chk("res", res, e_res);
    chk("cmplt0", {11'd0, cmplt0}, {11'd0, e_cmplt0});
    chk("cmplt1", {11'd0, cmplt1}, {11'd0, e_cmplt1});
    chk("busy", {11'd0, busy}, {11'd0, e_busy});
    chk("err", {11'd0, err_timeout}, {11'd0, e_err});
    chk("ovr0", {11'd0, ovr0}, {11'd0, e_ovr0});
    chk("ovr1", {11'd0, ovr1}, {11'd0, e_ovr1});
    req0_strt = 1'b0; req1_strt = 1'b0;
    a2d_update();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req0_strt = 1'b0; req1_strt = 1'b0;
    a2d_cnv_cmplt = 1'b0; rise_at = -1; fall_at = -1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_strt", {11'd0, a2d_strt_cnv}, 12'd0);
    chk("rst_chnnl", {9'd0, a2d_chnnl}, 12'd0);
    chk("rst_res", res, 12'd0);
    chk("rst_cmplt", {10'd0, cmplt1, cmplt0}, 12'd0);
    chk("rst_busy", {11'd0, busy}, 12'd0);
    chk("rst_err_ovr", {9'd0, err_timeout, ovr1, ovr0}, 12'd0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int t0, n, cnt, wcnt, ecyc, lcyc;
    bit seen;
    req0_chnnl = 3'd0; req1_chnnl = 3'd0; a2d_res = 12'd0;
    a2d_mode = 0; dly_lo = 1; dly_hi = 30; fix_res = 0; res_val = 12'd0;
    do_reset();

    // single request, 40-cycle conversion
    a2d_mode = 0; dly_lo = 40; dly_hi = 40; fix_res = 1; res_val = 12'hABC;
    t0 = cyc; req0_strt = 1'b1; req0_chnnl = 3'b001;
    step(); step();
    chk("t1_launch", {11'd0, a2d_strt_cnv}, 12'd1);
    chk("t1_chnnl", {9'd0, a2d_chnnl}, 12'h001);
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      if (cmplt0) begin
        seen = 1;
        chk("t1_res", res, 12'hABC);
        chk_i("t1_latency", cyc - t0, 2 + 40 + 1);
      end
    end
    chk_i("t1_done", int'(seen), 1);

    // tie after reset, then both re-strobed on every completion
    do_reset();
    fix_res = 0; dly_lo = 3; dly_hi = 8;
    req0_strt = 1'b1; req0_chnnl = 3'b000; req1_strt = 1'b1; req1_chnnl = 3'b110;
    n = 0;
    for (int i = 0; i < 300 && n < 6; i++) begin
      step();
      if (a2d_strt_cnv) begin
        chk("t2_alt", {9'd0, a2d_chnnl}, (n % 2 == 0) ? 12'h000 : 12'h006);
        n++;
      end
      if (cmplt0) begin req0_strt = 1'b1; req0_chnnl = 3'b000; end
      if (cmplt1) begin req1_strt = 1'b1; req1_chnnl = 3'b110; end
    end
    chk_i("t2_launches", n, 6);

    // timeout on req1 with req0 queued behind it
    do_reset();
    a2d_mode = 2;
    req1_strt = 1'b1; req1_chnnl = 3'b101;
    step(); step();
    chk("t3_launch", {11'd0, a2d_strt_cnv}, 12'd1);
    req0_strt = 1'b1; req0_chnnl = 3'b010;
    seen = 0; wcnt = 0; ecyc = 0;
    for (int i = 0; i < TMO + 20 && !seen; i++) begin
      step();
      if (busy && !a2d_strt_cnv) wcnt++;
      if (err_timeout) begin seen = 1; ecyc = cyc; end
    end
    chk_i("t3_err_seen", int'(seen), 1);
    chk_i("t3_wait_cycles", wcnt, TMO);
    seen = 0; lcyc = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      step();
      if (a2d_strt_cnv) begin seen = 1; lcyc = cyc; chk("t3_q_chnnl", {9'd0, a2d_chnnl}, 12'h002); end
    end
    chk_i("t3_queued_launch", lcyc, (ecyc - 1) + 2);

    // overrun during an in-flight req0
    do_reset();
    a2d_mode = 0; dly_lo = 20; dly_hi = 20; fix_res = 1; res_val = 12'h123;
    req0_strt = 1'b1; req0_chnnl = 3'b001;
    for (int i = 0; i < 5; i++) step();
    req0_strt = 1'b1; req0_chnnl = 3'b100;
    step();
    chk("t4_ovr0", {11'd0, ovr0}, 12'd1);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (cmplt0) begin seen = 1; chk("t4_chnnl", {9'd0, a2d_chnnl}, 12'h001); chk("t4_res", res, 12'h123); end
    end
    chk_i("t4_done", int'(seen), 1);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin step(); if (a2d_strt_cnv) cnt++; end
    chk_i("t4_no_relaunch", cnt, 0);

    // sticky completion level carried into the next WAIT
    do_reset();
    a2d_mode = 1; dly_lo = 5; dly_hi = 10; fix_res = 0;
    req0_strt = 1'b1; req0_chnnl = 3'b011;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin step(); if (cmplt0) seen = 1; end
    chk_i("t5_first", int'(seen), 1);
    chk("t5_level_high", {11'd0, a2d_cnv_cmplt}, 12'd1);
    req1_strt = 1'b1; req1_chnnl = 3'b111;
    cnt = 0;
    for (int i = 0; i < 80; i++) begin step(); if (cmplt1) cnt++; end
    chk_i("t5_cmplt_once", cnt, 1);

    // reset while WAIT is active and both requesters are pending
    do_reset();
    a2d_mode = 2;
    req0_strt = 1'b1; req1_strt = 1'b1; req0_chnnl = 3'b010; req1_chnnl = 3'b100;
    for (int i = 0; i < 6; i++) step();
    rst_n = 1'b0; #2;
    chk("t6_busy_async", {11'd0, busy}, 12'd0);
    do_reset();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin step(); if (a2d_strt_cnv || busy) cnt++; end
    chk_i("t6_no_launch", cnt, 0);

    // randomized traffic
    do_reset();
    dly_lo = 1; dly_hi = 30;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) a2d_mode = int'($urandom_range(0, 1));
      req0_strt = ($urandom_range(0, 7) == 0); req0_chnnl = 3'($urandom);
      req1_strt = ($urandom_range(0, 7) == 0); req1_chnnl = 3'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
